// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: state encoding, port ids and latency-counter sizing for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        ACCESS = 4'b0010,
        WAIT   = 4'b0100,
        RESP   = 4'b1000
    } state_t;
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;
    // Wide enough to hold READ_LAT-1, never narrower than one bit
    function automatic int cnt_width(input int lat);
        return lat < 2 ? 1 : $clog2(lat);
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; on contention the port that did not win last time goes
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       any
);
    always_comb begin
        any = |req;
        winner = &req ? ~last_owner : req[1];
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency memory port between fetch (0) and data (1)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int READ_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_done,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_done,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    localparam int CW = cnt_width(READ_LAT);

    state_t                state;
    logic                  owner, owner_we, last_owner, winner, any;
    logic                  arb, win_we, capture, to_resp;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    rr_arbiter2 u_rr (
        .req       ({p1_req, p0_req}),
        .last_owner(last_owner),
        .winner    (winner),
        .any       (any)
    );

    always_comb begin
        arb = (state == IDLE) || (state == RESP);
        win_we = winner == PORT_DATA ? p1_we : p0_we;
        win_addr = winner == PORT_DATA ? p1_addr : p0_addr;
        win_wdata = winner == PORT_DATA ? p1_wdata : p0_wdata;
        capture = (state == WAIT) && (cnt == '0);
        to_resp = capture || ((state == ACCESS) && owner_we);
    end

    // Every output is a register; the RESP cycle both signals done and starts the next grant
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= PORT_FETCH;
            owner_we <= 1'b0;
            last_owner <= PORT_DATA;
            cnt <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            p0_gnt <= 1'b0;
            p1_gnt <= 1'b0;
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
            busy <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            p0_gnt <= 1'b0;
            p1_gnt <= 1'b0;
            p0_done <= to_resp && owner == PORT_FETCH;
            p1_done <= to_resp && owner == PORT_DATA;
            busy <= 1'b1;
            if (capture && owner == PORT_FETCH) p0_rdata <= mem_rdata;
            if (capture && owner == PORT_DATA) p1_rdata <= mem_rdata;
            if (arb) begin
                if (any) begin
                    state <= ACCESS;
                    owner <= winner;
                    last_owner <= winner;
                    owner_we <= win_we;
                    mem_addr <= win_addr;
                    mem_wdata <= win_wdata;
                    mem_rd <= !win_we;
                    mem_wr <= win_we;
                    p0_gnt <= winner == PORT_FETCH;
                    p1_gnt <= winner == PORT_DATA;
                end else begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            end else if (state == ACCESS) begin
                state <= owner_we ? RESP : WAIT;
                cnt <= CW'(READ_LAT - 1);
            end else begin
                state <= capture ? RESP : WAIT;
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors and corner sequences for the memory port arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p0_done, p1_gnt, p1_done, mem_rd, mem_wr, busy;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        q_p0_gnt, q_p0_done, q_p1_gnt, q_p1_done, q_mem_rd, q_mem_wr, q_busy;
    logic [31:0] q_p0_rdata, q_p1_rdata, q_mem_addr, q_mem_wdata, q_mem_rdata;
    logic        s1_v = 1'b0, s2_v = 1'b0, t1_v = 1'b0;
    logic [31:0] s1_a = '0, s2_a = '0, t1_a = '0;
    int          checks = 0, errors = 0;

    typedef struct {
        logic        r0, we0;
        logic [31:0] a0;
        logic        r1, we1;
        logic [31:0] a1, d1;
        logic [6:0]  ctl;
        logic [31:0] ea, ed, e0, e1;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a == 32'h10 ? 32'hDEADBEEF : a == 32'h20 ? 32'hA5A5A5A5 : a ^ 32'h5A5A0000;
    endfunction

    // Memory model: data is valid only in the single cycle READ_LAT after the read strobe
    always @(posedge clk) begin
        s1_v <= mem_rd;
        s1_a <= mem_addr;
        s2_v <= s1_v;
        s2_a <= s1_a;
        t1_v <= q_mem_rd;
        t1_a <= q_mem_addr;
    end
    assign mem_rdata = s2_v ? data_of(s2_a) : 32'hBAD0BAD0;
    assign q_mem_rdata = t1_v ? data_of(t1_a) : 32'hBAD0BAD0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(q_p0_gnt), .p0_done(q_p0_done), .p0_rdata(q_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(q_p1_gnt), .p1_done(q_p1_done), .p1_rdata(q_p1_rdata),
        .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata), .mem_rd(q_mem_rd), .mem_wr(q_mem_wr),
        .mem_rdata(q_mem_rdata), .busy(q_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n, both, dn;
        logic       own[6];
        int         at[6];
        logic [9:0] wm, dm;
        // ctl = {p0_gnt, p1_gnt, p0_done, p1_done, mem_rd, mem_wr, busy} one cycle after the inputs
        tbl[0] = '{1, 0, 32'h10, 0, 0, 0, 0, 7'b1000101, 32'h10, 0, 0, 0};
        tbl[1] = '{1, 0, 32'h10, 0, 0, 0, 0, 7'b0000001, 32'h10, 0, 0, 0};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 7'b0000001, 32'h10, 0, 0, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 7'b0010001, 32'h10, 0, 32'hDEADBEEF, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 7'b0000000, 32'h10, 0, 32'hDEADBEEF, 0};
        tbl[5] = '{0, 0, 0, 1, 1, 32'h40, 32'h12345678, 7'b0100011, 32'h40, 32'h12345678, 32'hDEADBEEF, 0};
        tbl[6] = '{0, 0, 0, 1, 1, 32'h40, 32'h12345678, 7'b0001001, 32'h40, 32'h12345678, 32'hDEADBEEF, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 7'b0000000, 32'h40, 32'h12345678, 32'hDEADBEEF, 0};

        do_reset();
        chk("reset_state", {p0_gnt, p1_gnt, p0_done, p1_done, mem_rd, mem_wr, busy, mem_addr, mem_wdata, p0_rdata, p1_rdata}, '0);
        for (int i = 0; i < 8; i++) begin
            p0_req = tbl[i].r0; p0_we = tbl[i].we0; p0_addr = tbl[i].a0;
            p1_req = tbl[i].r1; p1_we = tbl[i].we1; p1_addr = tbl[i].a1; p1_wdata = tbl[i].d1;
            step();
            chk($sformatf("ctl[%0d]", i), {p0_gnt, p1_gnt, p0_done, p1_done, mem_rd, mem_wr, busy}, tbl[i].ctl);
            chk($sformatf("mem_bus[%0d]", i), {mem_addr, mem_wdata}, {tbl[i].ea, tbl[i].ed});
            chk($sformatf("p0_rdata[%0d]", i), p0_rdata, tbl[i].e0);
            chk($sformatf("p1_rdata[%0d]", i), p1_rdata, tbl[i].e1);
        end

        // Both ports reading continuously: strict alternation, fetch first, READ_LAT+2 apart
        do_reset();
        p0_req = 1'b1; p0_addr = 32'h100;
        p1_req = 1'b1; p1_addr = 32'h200;
        n = 0;
        both = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (p0_gnt && p1_gnt) both++;
            if ((p0_gnt || p1_gnt) && n < 6) begin
                own[n] = p1_gnt;
                at[n] = c;
                n++;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        step();
        step();
        step();
        step();
        chk("rr_grants", n, 6);
        for (int i = 0; i < n; i++) chk($sformatf("rr_owner[%0d]", i), own[i], i % 2);
        for (int i = 1; i < n; i++) chk($sformatf("rr_gap[%0d]", i), at[i] - at[i-1], 4);
        chk("rr_both_gnt", both, 0);
        chk("rr_p0_rdata", p0_rdata, 32'h5A5A0100);
        chk("rr_p1_rdata", p1_rdata, 32'h5A5A0200);

        // Port 0 back-to-back writes: a strobe every other cycle
        do_reset();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h80; p0_wdata = 32'hCAFE;
        for (int k = 0; k < 6 && !mem_wr; k++) step();
        chk("wr_first", mem_wr, 1);
        for (int k = 0; k < 10; k++) begin
            wm[k] = mem_wr;
            dm[k] = p0_done;
            step();
        end
        p0_req = 1'b0;
        chk("wr_strobes", wm, 10'h155);
        chk("wr_dones", dm, 10'h2AA);
        chk("wr_rdata", {p0_rdata, p1_rdata}, '0);

        // Reset during the first WAIT of a port 1 read
        do_reset();
        p1_req = 1'b1; p1_addr = 32'h30;
        for (int k = 0; k < 6 && !p1_gnt; k++) step();
        chk("rst_gnt1", {p1_gnt, mem_rd}, 2'b11);
        p1_req = 1'b0;
        step();
        chk("rst_in_wait", {busy, mem_rd, p1_done}, 3'b100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_after", {busy, mem_rd, mem_wr, p1_done}, 4'b0000);
        dn = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            dn += int'(p1_done);
        end
        chk("rst_no_done", dn, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        p0_req = 1'b1; p0_addr = 32'h10;
        step();
        chk("rst_regrant", {p0_gnt, p1_gnt, mem_rd}, 3'b101);
        p0_req = 1'b0;
        for (int k = 0; k < 8 && !p0_done; k++) step();
        chk("rst_p0_done", {p0_done, p0_rdata}, {1'b1, 32'hDEADBEEF});

        // READ_LAT=1 instance: done two cycles after the strobe, next read one cycle later
        do_reset();
        p1_req = 1'b1; p1_addr = 32'h20;
        for (int k = 0; k < 6 && !q_p1_gnt; k++) step();
        chk("l1_access", {q_p1_gnt, q_mem_rd}, 2'b11);
        step();
        chk("l1_wait", {q_p1_done, q_busy, q_mem_rd}, 3'b010);
        step();
        chk("l1_done", {q_p1_done, q_p1_rdata}, {1'b1, 32'hA5A5A5A5});
        step();
        chk("l1_next", {q_p1_gnt, q_mem_rd}, 2'b11);
        p1_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
